// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite read-side clients.
package sprite_pkg;

  localparam int CRD_W  = 10;  // screen coordinate width
  localparam int PIX_W  = 4;   // palette index width
  localparam int ADDR_W = 19;  // sprite ROM address width

  // Palette index that the colour mapper treats as see-through
  localparam logic [PIX_W-1:0] TRANSPARENT = 4'h0;

  typedef logic [CRD_W-1:0] coord_t;
  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/sprite_line_buf.sv
// One sprite row of palette indices: single write port, combinational read.
module sprite_line_buf
  import sprite_pkg::*;
#(
  parameter int DEPTH = 20,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  pix_t             wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output pix_t             rd_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // Contents are deliberately left unreset; line_hit in the fetcher gates any stale data.
  pix_t mem [DEPTH];

  // Capture one ROM word per write strobe; out-of-range indices are dropped.
  always_ff @(posedge Clk) begin
    if (wr_en && (wr_idx <= LAST_IDX)) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Indices beyond the row read as transparent so the caller never sees garbage.
  assign rd_data = (rd_idx <= LAST_IDX) ? mem[rd_idx] : '0;

endmodule

// File: rtl/sprite_line_fetcher.sv
// Fetches the sprite row covering the next scanline into a line buffer during
// hblank, then answers per-pixel palette queries for the colour mapper.
module sprite_line_fetcher
  import sprite_pkg::*;
#(
  parameter int SPR_W = 20,
  parameter int SPR_H = 14
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              line_start,
  input  coord_t            line_y,
  input  coord_t            spr_x,
  input  coord_t            spr_y,
  input  logic              spr_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  pix_t              rom_data,
  input  coord_t            draw_x,
  output pix_t              pix_out,
  output logic              pix_valid,
  output logic              busy
);

  localparam int IDX_W = $clog2(SPR_W);

  localparam logic [IDX_W-1:0]        COL_PENULT = IDX_W'(SPR_W - 2);
  localparam logic [IDX_W-1:0]        COL_LAST   = IDX_W'(SPR_W - 1);
  localparam logic [CRD_W:0]          SPR_W_X    = (CRD_W + 1)'(SPR_W);
  localparam logic signed [CRD_W:0]   SPR_H_S    = (CRD_W + 1)'(SPR_H);
  localparam logic [ADDR_W-1:0]       SPR_W_A    = ADDR_W'(SPR_W);

  fetch_state_t      state_reg;
  coord_t            sx_reg;        // sprite left edge latched for the whole line
  logic              line_hit_reg;  // buffer holds a valid row for the current line
  logic [IDX_W-1:0]  col_reg;       // offset of the address currently on rom_addr
  logic [IDX_W-1:0]  wr_idx_reg;    // next buffer slot to fill
  logic              req_reg;       // rom_addr carries a live fetch address
  logic              cap_reg;       // rom_data carries a word to capture this cycle
  logic [ADDR_W-1:0] rom_addr_reg;
  logic              busy_reg;
  pix_t              pix_out_reg;
  logic              pix_valid_reg;

  // Row of the sprite that the upcoming line falls on; sign bit flags lines above the sprite.
  logic signed [CRD_W:0] row;
  logic                  row_ok;
  logic [ADDR_W-1:0]     row_base;

  assign row      = $signed({1'b0, line_y}) - $signed({1'b0, spr_y});
  assign row_ok   = spr_en && !row[CRD_W] && (row < SPR_H_S);
  assign row_base = ADDR_W'(row[CRD_W-1:0]) * SPR_W_A;

  // Horizontal offset into the sprite; unsigned compare rejects pixels left of the sprite.
  logic [CRD_W:0]   dx;
  logic             pix_hit;
  logic [IDX_W-1:0] rd_idx;
  pix_t             buf_pix;

  assign dx      = {1'b0, draw_x} - {1'b0, sx_reg};
  assign pix_hit = line_hit_reg && (dx < SPR_W_X);
  assign rd_idx  = dx[IDX_W-1:0];

  sprite_line_buf #(
    .DEPTH (SPR_W),
    .IDX_W (IDX_W)
  ) u_line_buf (
    .Clk     (Clk),
    .wr_en   (cap_reg),
    .wr_idx  (wr_idx_reg),
    .wr_data (rom_data),
    .rd_idx  (rd_idx),
    .rd_data (buf_pix)
  );

  // Fetch controller: accept a line start in IDLE, stream SPR_W addresses, wait out ROM latency.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= ST_IDLE;
      sx_reg       <= '0;
      line_hit_reg <= 1'b0;
      col_reg      <= '0;
      req_reg      <= 1'b0;
      rom_addr_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (line_start) begin
            sx_reg       <= spr_x;
            line_hit_reg <= 1'b0;
            if (row_ok) begin
              rom_addr_reg <= row_base;
              col_reg      <= '0;
              req_reg      <= 1'b1;
              busy_reg     <= 1'b1;
              state_reg    <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          rom_addr_reg <= rom_addr_reg + 1'b1;
          col_reg      <= col_reg + 1'b1;
          if (col_reg == COL_PENULT) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The last address was presented one cycle ago; stop flagging new requests.
          req_reg <= 1'b0;
          if (cap_reg && (wr_idx_reg == COL_LAST)) begin
            line_hit_reg <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Capture side lags the address side by the ROM's one-cycle read latency.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cap_reg    <= 1'b0;
      wr_idx_reg <= '0;
    end else begin
      cap_reg <= req_reg;
      if (state_reg == ST_IDLE) begin
        wr_idx_reg <= '0;
      end else if (cap_reg) begin
        wr_idx_reg <= wr_idx_reg + 1'b1;
      end
    end
  end

  // Pixel lookup with one cycle of latency; transparent or off-sprite pixels report invalid.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_out_reg   <= '0;
      pix_valid_reg <= 1'b0;
    end else begin
      pix_out_reg   <= pix_hit ? buf_pix : '0;
      pix_valid_reg <= pix_hit && (buf_pix != TRANSPARENT);
    end
  end

  assign rom_addr  = rom_addr_reg;
  assign busy      = busy_reg;
  assign pix_out   = pix_out_reg;
  assign pix_valid = pix_valid_reg;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Scoreboard bench for sprite_line_fetcher with a behavioural 1-cycle ROM.
module tb_sprite_line_fetcher;
  import sprite_pkg::*;

  localparam int SPR_W = 20;
  localparam int SPR_H = 14;
  localparam int ROM_D = SPR_W * SPR_H;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              line_start = 1'b0;
  coord_t            line_y = '0;
  coord_t            spr_x = '0;
  coord_t            spr_y = '0;
  logic              spr_en = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  pix_t              rom_data = '0;
  coord_t            draw_x = '0;
  pix_t              pix_out;
  logic              pix_valid;
  logic              busy;

  always #5 Clk = ~Clk;

  sprite_line_fetcher #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .line_start (line_start),
    .line_y     (line_y),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_en     (spr_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .draw_x     (draw_x),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .busy       (busy)
  );

  // Sprite ROM preloaded with mem[k] = k % 16, synchronous read.
  pix_t rom_mem [ROM_D];
  initial begin
    for (int k = 0; k < ROM_D; k++) rom_mem[k] = pix_t'(k % 16);
  end
  always @(posedge Clk) begin
    rom_data <= (int'(rom_addr) < ROM_D) ? rom_mem[rom_addr] : '0;
  end

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int x;
    int pix;
    int vld;
  } pix_exp_t;

  int       addr_q[$];
  pix_exp_t pix_q[$];

  // Reference model of what the line buffer should hold
  int m_hit = 0;
  int m_row = 0;
  int m_sx  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pop_pix();
    pix_exp_t e;
    e = pix_q.pop_front();
    check_val($sformatf("pix_out x=%0d", e.x), 32'(pix_out), e.pix);
    check_val($sformatf("pix_valid x=%0d", e.x), 32'(pix_valid), e.vld);
  endtask

  task automatic sweep(input int x0, input int x1);
    pix_exp_t e;
    int dx;
    for (int x = x0; x <= x1; x++) begin
      @(negedge Clk);
      if (pix_q.size() > 0) pop_pix();
      draw_x = coord_t'(x);
      dx = x - m_sx;
      e.x = x;
      if (m_hit != 0 && dx >= 0 && dx < SPR_W) begin
        e.pix = (m_row * SPR_W + dx) % 16;
        e.vld = (e.pix != int'(TRANSPARENT)) ? 1 : 0;
      end else begin
        e.pix = 0;
        e.vld = 0;
      end
      pix_q.push_back(e);
    end
    @(negedge Clk);
    if (pix_q.size() > 0) pop_pix();
    $display("sweep x=%0d..%0d sx=%0d hit=%0d", x0, x1, m_sx, m_hit);
  endtask

  // Issue a line_start; inject_at >= 1 pulses a second line_start that many cycles in.
  task automatic run_fetch(input int ly, input int inject_at);
    int row;
    int busy_cnt;
    int prev_addr;
    bit hit;
    row       = ly - int'(spr_y);
    hit       = spr_en && row >= 0 && row < SPR_H;
    prev_addr = int'(rom_addr);
    busy_cnt  = 0;
    if (hit) for (int k = 0; k < SPR_W; k++) addr_q.push_back(row * SPR_W + k);
    @(negedge Clk);
    draw_x     = coord_t'(int'(spr_x) + 1);
    line_y     = coord_t'(ly);
    line_start = 1'b1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge Clk);
      line_start = (cyc == inject_at);
      if (cyc == inject_at) line_y = coord_t'(ly + 7);
      if (busy) begin
        busy_cnt++;
        if (cyc >= 1) check_val($sformatf("pix_valid_in_fetch[%0d]", cyc), 32'(pix_valid), 0);
      end
      if (addr_q.size() > 0) check_val($sformatf("rom_addr[%0d]", cyc), 32'(rom_addr), addr_q.pop_front());
    end
    line_start = 1'b0;
    line_y     = coord_t'(ly);
    check_val($sformatf("busy_cycles ly=%0d", ly), busy_cnt, hit ? SPR_W + 1 : 0);
    if (!hit) check_val($sformatf("rom_addr_hold ly=%0d", ly), 32'(rom_addr), prev_addr);
    m_hit = hit ? 1 : 0;
    m_row = row;
    m_sx  = int'(spr_x);
    $display("fetch line_y=%0d en=%0d row=%0d hit=%0d busy_cycles=%0d", ly, spr_en, row, hit, busy_cnt);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check_val("reset rom_addr", 32'(rom_addr), 0);
    check_val("reset busy", 32'(busy), 0);
    check_val("reset pix_out", 32'(pix_out), 0);
    check_val("reset pix_valid", 32'(pix_valid), 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Basic hit on row 3, then sweep around the sprite
    spr_en = 1'b1;
    spr_y  = coord_t'(100);
    spr_x  = coord_t'(200);
    run_fetch(103, -1);
    sweep(195, 225);

    // Lines just outside the sprite and a disabled sprite
    run_fetch(99, -1);
    sweep(198, 222);
    run_fetch(114, -1);
    sweep(198, 222);
    spr_en = 1'b0;
    run_fetch(103, -1);
    sweep(198, 222);
    spr_en = 1'b1;

    // Last sprite row
    run_fetch(113, -1);
    sweep(198, 222);

    // Second line_start during a fetch is ignored
    run_fetch(103, 5);
    sweep(198, 222);

    // Asynchronous reset in the middle of a fetch
    @(negedge Clk);
    line_y     = coord_t'(103);
    line_start = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge Clk);
      line_start = 1'b0;
      check_val($sformatf("pre_reset rom_addr[%0d]", cyc), 32'(rom_addr), 60 + cyc);
    end
    #2 Reset_n = 1'b0;
    #1;
    check_val("midreset rom_addr", 32'(rom_addr), 0);
    check_val("midreset busy", 32'(busy), 0);
    check_val("midreset pix_out", 32'(pix_out), 0);
    check_val("midreset pix_valid", 32'(pix_valid), 0);
    $display("reset asserted mid-fetch");
    @(negedge Clk);
    Reset_n = 1'b1;
    m_hit = 0;
    sweep(200, 204);
    run_fetch(105, -1);
    sweep(198, 222);

    // Sprite straddling the right screen edge, then the left edge of the next sweep
    spr_x = coord_t'(630);
    run_fetch(103, -1);
    sweep(625, 639);
    sweep(0, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sprite_line_fetcher.md
Name: sprite_line_fetcher

Overview:
- Read-side client for a sprite palette ROM: a synchronous ROM with 1-cycle read latency and 4-bit palette-index output.
- On each scanline-start pulse (issued during hblank), checks whether the sprite covers the next line.
- If it does, fetches that sprite row from ROM into an internal line buffer.
- During the active line, answers per-pixel queries from the VGA draw position with a palette index plus a non-transparent valid flag, for the colour mapper.

Parameters:
SPR_W, 20, sprite width in pixels
SPR_H, 14, sprite height in lines (SPR_W*SPR_H = ROM depth, 280)
ADDR_W, 19, ROM address width
PIX_W, 4, palette index width
CRD_W, 10, screen coordinate width
TRANSPARENT, 4'h0, palette index treated as see-through

Ports:
Clk  in  1  system clock; all state on rising edge
Reset_n  in  1  asynchronous, active-low reset
line_start  in  1  one-cycle pulse: begin fetch for line line_y
line_y  in  CRD_W  screen Y of the line about to be drawn
spr_x  in  CRD_W  sprite left edge (screen X)
spr_y  in  CRD_W  sprite top edge (screen Y)
spr_en  in  1  sprite visible this frame
rom_addr  out  ADDR_W  read address to sprite ROM (registered)
rom_data  in  PIX_W  ROM data, valid 1 cycle after address is sampled
draw_x  in  CRD_W  current VGA pixel X
pix_out  out  PIX_W  palette index for draw_x (registered)
pix_valid  out  1  pix_out is a non-transparent sprite pixel
busy  out  1  fetch in progress; line_start is ignored while high

Behaviour:
- Reset (async, Reset_n=0): state=IDLE, rom_addr=0, pix_out=0, pix_valid=0, busy=0, line_hit=0, latched coords=0. Line buffer contents are not reset.
- States: IDLE, FETCH, DRAIN.
- IDLE, line_start=1 at edge E0:
  - Latch spr_x into sx_l.
  - Compute row = line_y - spr_y as an (CRD_W+1)-bit signed value; clear line_hit.
  - If spr_en && 0 <= row < SPR_H: rom_addr <= row*SPR_W, col <= 0, busy <= 1, go to FETCH.
  - Else: stay in IDLE with line_hit=0.
- FETCH: at each edge rom_addr increments by 1 until address row*SPR_W+SPR_W-1 has been presented, which happens at edge E0+SPR_W-1. Then go to DRAIN.
- Data capture: buf[i] <= rom_data at edge E0+i+2, for i = 0..SPR_W-1. A write counter starts at E0+2.
- DRAIN: 2 cycles to capture the final words. At edge E0+SPR_W+1, buf[SPR_W-1] is written, line_hit <= 1, busy <= 0, go to IDLE.
- busy is high for exactly SPR_W+1 cycles. rom_addr holds its last value in IDLE.
- line_start while busy=1: ignored, no state change. line_start coincident with reset: reset wins.
- Pixel path, 1-cycle latency. At each edge:
  - dx = {0,draw_x} - {0,sx_l}, (CRD_W+1)-bit.
  - hit = line_hit && dx < SPR_W, with dx treated as unsigned so negative differences fail.
  - pix_out <= hit ? buf[dx] : 0.
  - pix_valid <= hit && buf[dx] != TRANSPARENT.
- No horizontal wrap: sprites extending past the right screen edge are clipped naturally, because draw_x never reaches those columns during active video.
- line_hit stays 0 from line_start acceptance until the fetch completes, so pix_valid=0 throughout any fetch.
- Reset mid-FETCH: immediate return to IDLE, busy=0, line_hit=0. The next line_start restarts cleanly.

Decomposition:
- Shared package sprite_pkg: CRD_W, PIX_W, ADDR_W, TRANSPARENT, and typedefs coord_t and pix_t. This package is reused by the other sprite clients.
- One sub-module, sprite_line_buf: SPR_W x PIX_W register array with 1 write port and 1 async read port.
- FSM, address counter and pixel path stay in the top module.

Test Plan:
- ROM preloaded with mem[k]=k%16; spr_en=1, spr_y=100, line_y=103, line_start pulse -> rom_addr runs 60..79 on consecutive cycles; busy high 21 cycles; buf[i]=(60+i)%16.
- After the previous scenario, spr_x=200, sweep draw_x 195..225 -> 1 cycle later pix_valid=1 for x=200..219 except where (60+x-200)%16==0 (x=204, 220 not in range) -> valid at x 200..219 minus x=204, pix_out=(x-140)%16; 0 outside.
- line_y=99 or 114 (row -1, 14), or spr_en=0 -> no FETCH, busy stays 0, pix_valid=0 across the whole line.
- Second line_start 5 cycles into a fetch -> ignored; rom_addr sequence unbroken; busy still falls at E0+21.
- Reset_n low at E0+8 -> outputs zero asynchronously, busy=0, line_hit=0; new line_start after release fetches the full row correctly.
- spr_x=630, line hit, draw_x 625..639 -> pix_valid only for x 630..639, no wrap artefacts at x 0..9 on the next sweep.
